// File: rtl/pn_checker.sv
// PN sequence checker: seeds an LFSR model from the received stream, tracks and locks onto it,
// flywheels through errors, counts mismatches and measures the sequence period.
module pn_checker #(
  parameter int WIDTH    = 13,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_word,
  input  logic [3:0]       num,
  input  logic [WIDTH-1:0] char_poly,
  output logic             locked,
  output logic             mismatch,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {SEED, TRACK, LOCKED} state_t;

  function automatic logic [WIDTH-1:0] len_mask(input logic [3:0] n_raw);
    logic [3:0]       n;
    logic [WIDTH-1:0] m;
    n = (n_raw < 4'd2) ? 4'd2 : ((n_raw > 4'd13) ? 4'd13 : n_raw);
    for (int i = 0; i < WIDTH; i++) m[i] = (i < int'(n));
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] poly,
                                                 input logic [WIDTH-1:0] mask);
    logic [WIDTH-1:0] sm;
    logic             f;
    sm = s & mask;
    f  = ^(sm & poly);
    return {sm[WIDTH-2:0], f} & mask;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d, exp_q, exp_d, step_q, step_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    loss_q, loss_d;
  logic [3:0]       num_q, num_d;
  logic [WIDTH-1:0] poly_q, poly_d;
  logic             locked_q, locked_d, mismatch_q, mismatch_d, pv_q, pv_d;
  logic [7:0]       err_q, err_d;
  logic [WIDTH-1:0] period_q, period_d;

  logic [WIDTH-1:0] mask_use, poly_use, word_m, seed_exp, next_exp, step_inc;
  logic             cfg_changed, is_match;

  // In SEED the live config applies; afterwards the config captured at seed time is used.
  always_comb begin
    mask_use    = len_mask((state_q == SEED) ? num : num_q);
    poly_use    = (state_q == SEED) ? char_poly : poly_q;
    word_m      = in_word & mask_use;
    seed_exp    = lfsr_next(word_m, poly_use, mask_use);
    next_exp    = lfsr_next(exp_q, poly_use, mask_use);
    is_match    = (word_m == exp_q);
    step_inc    = (step_q == {WIDTH{1'b1}}) ? step_q : step_q + 1'b1;
    cfg_changed = (state_q != SEED) && ((num != num_q) || (char_poly != poly_q));
  end

  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    exp_d      = exp_q;
    step_d     = step_q;
    match_d    = match_q;
    loss_d     = loss_q;
    num_d      = num_q;
    poly_d     = poly_q;
    pv_d       = pv_q;
    period_d   = period_q;
    mismatch_d = 1'b0;

    if (cfg_changed) begin
      state_d = SEED;
      pv_d    = 1'b0;
    end else if (in_valid) begin
      case (state_q)
        SEED: begin
          if (word_m != '0) begin
            state_d = TRACK;
            ref_d   = word_m;
            exp_d   = seed_exp;
            match_d = '0;
            loss_d  = '0;
            step_d  = WIDTH'(1);
            num_d   = num;
            poly_d  = char_poly;
            pv_d    = 1'b0;
          end
        end
        TRACK: begin
          if (is_match) begin
            match_d = match_q + 1'b1;
            exp_d   = next_exp;
            step_d  = step_inc;
            if (match_q == MW'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              loss_d  = '0;
            end
          end else begin
            mismatch_d = 1'b1;
            if (word_m == '0) begin
              state_d = SEED;
            end else begin
              ref_d   = word_m;
              exp_d   = seed_exp;
              match_d = '0;
              step_d  = WIDTH'(1);
              pv_d    = 1'b0;
            end
          end
        end
        LOCKED: begin
          exp_d  = next_exp;
          step_d = step_inc;
          if (is_match) begin
            loss_d = '0;
            if ((word_m == ref_q) && !pv_q) begin
              period_d = step_q;
              pv_d     = 1'b1;
            end
          end else begin
            mismatch_d = 1'b1;
            if (loss_q == LW'(LOSS_CNT - 1)) begin
              state_d = SEED;
              pv_d    = 1'b0;
              loss_d  = '0;
            end else begin
              loss_d = loss_q + 1'b1;
            end
          end
        end
        default: state_d = SEED;
      endcase
    end

    err_d    = (mismatch_d && (err_q != 8'hFF)) ? err_q + 1'b1 : err_q;
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEED;
      ref_q      <= '0;
      exp_q      <= '0;
      step_q     <= '0;
      match_q    <= '0;
      loss_q     <= '0;
      num_q      <= '0;
      poly_q     <= '0;
      pv_q       <= 1'b0;
      period_q   <= '0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      exp_q      <= exp_d;
      step_q     <= step_d;
      match_q    <= match_d;
      loss_q     <= loss_d;
      num_q      <= num_d;
      poly_q     <= poly_d;
      pv_q       <= pv_d;
      period_q   <= period_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
    end
  end

  assign locked       = locked_q;
  assign mismatch     = mismatch_q;
  assign err_count    = err_q;
  assign period       = period_q;
  assign period_valid = pv_q;

endmodule
